// File: rtl/led_status_ctrl.sv
// led_status_ctrl: front-panel power / fault / identify LED sequencer.
// Optional feature macro: LED_LAMP_TEST_EN enables the power-up lamp test.
//
// Ports:
//   SYSCLK, RESET_N        clock, asynchronous active-low reset
//   CLK_1HZ..CLK_07S       SYSCLK-synchronous blink waves from the LED counter
//   PWR_GOOD, BMC_READY    power / management-controller status levels
//   FAULT_IN, FAULT_CLR    fault level and one-cycle clear request
//   ID_REQ                 identify request level (rising edge toggles)
//   LED_PWR_N/FAULT_N/ID_N active-low registered LED drives
//   FAULT_LATCHED          sticky fault status
//   ID_ACTIVE              identify status
//   STATE                  00 LAMP, 01 WAIT, 10 RUN
module led_status_ctrl #(
    parameter int unsigned LAMP_SEC   = 2,
    parameter int unsigned ID_TIMEOUT = 60
) (
    input  logic       SYSCLK,
    input  logic       RESET_N,
    input  logic       CLK_1HZ,
    input  logic       CLK_2HZ,
    input  logic       CLK_4HZ,
    input  logic       CLK_4HZ_500MS,
    input  logic       CLK_4HZ_3500MS,
    input  logic       CLK_07S,
    input  logic       PWR_GOOD,
    input  logic       BMC_READY,
    input  logic       FAULT_IN,
    input  logic       FAULT_CLR,
    input  logic       ID_REQ,
    output logic       LED_PWR_N,
    output logic       LED_FAULT_N,
    output logic       LED_ID_N,
    output logic       FAULT_LATCHED,
    output logic       ID_ACTIVE,
    output logic [1:0] STATE
);

    localparam logic [1:0] ST_LAMP = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    localparam int unsigned ID_CNT_W = 8;
    localparam logic [ID_CNT_W-1:0] ID_LIMIT = ID_CNT_W'(ID_TIMEOUT);

`ifdef LED_LAMP_TEST_EN
    localparam logic [3:0] LAMP_LIMIT = 4'(LAMP_SEC);
    localparam logic [1:0] ST_RESET   = ST_LAMP;
`else
    localparam logic [1:0] ST_RESET   = ST_WAIT;
`endif

    // Elaboration-time parameter range checks
    if (LAMP_SEC < 1 || LAMP_SEC > 15) begin : g_bad_lamp_sec
        $error("LAMP_SEC must be in 1..15");
    end
    if (ID_TIMEOUT > 255) begin : g_bad_id_timeout
        $error("ID_TIMEOUT must be in 0..255");
    end

    // The slow 0.7 s wave is part of the shared blink bus but drives nothing here
    logic w_unused;
    assign w_unused = CLK_07S;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_clk1_prev;
    logic                r_id_prev;
    logic                r_fault;
    logic                r_id_active;
    logic [ID_CNT_W-1:0] r_id_cnt;
    logic [ID_CNT_W-1:0] w_id_cnt_inc;
    logic                r_led_pwr_n;
    logic                r_led_fault_n;
    logic                r_led_id_n;
    logic                w_tick;
    logic                w_id_edge;
    logic                w_in_lamp;
    logic                w_pwr_on;
    logic                w_fault_on;
    logic                w_id_on;

    assign w_tick       = CLK_1HZ & ~r_clk1_prev;
    assign w_id_edge    = ID_REQ & ~r_id_prev;
    assign w_id_cnt_inc = r_id_cnt + ID_CNT_W'(1);

`ifdef LED_LAMP_TEST_EN
    logic [3:0] r_lamp_cnt;

    assign w_in_lamp = (r_state == ST_LAMP);

    // Lamp-test second counter
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_lamp_cnt <= 4'd0;
        end else if (w_in_lamp && w_tick) begin
            r_lamp_cnt <= r_lamp_cnt + 4'd1;
        end
    end
`else
    assign w_in_lamp = 1'b0;
`endif

    // State register
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the unused 11 code recovers to WAIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LAMP: begin
`ifdef LED_LAMP_TEST_EN
                if (w_tick && (r_lamp_cnt == LAMP_LIMIT - 4'd1)) begin
                    w_state_nxt = ST_WAIT;
                end
`else
                w_state_nxt = ST_WAIT;
`endif
            end
            ST_WAIT: if (PWR_GOOD)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!PWR_GOOD) w_state_nxt = ST_WAIT;
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    // Edge-detect history
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_clk1_prev <= 1'b0;
            r_id_prev   <= 1'b0;
        end else begin
            r_clk1_prev <= CLK_1HZ;
            r_id_prev   <= ID_REQ;
        end
    end

    // Fault latch: set has priority over clear
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_fault <= 1'b0;
        end else if (!w_in_lamp) begin
            if (FAULT_IN) begin
                r_fault <= 1'b1;
            end else if (FAULT_CLR) begin
                r_fault <= 1'b0;
            end
        end
    end

    // Identify toggle with auto-timeout; a request edge beats the timeout
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_id_active <= 1'b0;
            r_id_cnt    <= '0;
        end else if (!w_in_lamp && w_id_edge) begin
            r_id_active <= ~r_id_active;
            r_id_cnt    <= '0;
        end else if (r_id_active && (ID_LIMIT != '0) && w_tick) begin
            if (w_id_cnt_inc == ID_LIMIT) begin
                r_id_active <= 1'b0;
                r_id_cnt    <= '0;
            end else begin
                r_id_cnt    <= w_id_cnt_inc;
            end
        end
    end

    // LED-on terms
    always_comb begin
        w_pwr_on   = 1'b0;
        w_fault_on = FAULT_IN ? CLK_4HZ : (r_fault & CLK_4HZ_3500MS);
        w_id_on    = r_id_active & CLK_4HZ_500MS;
        case (r_state)
            ST_WAIT: w_pwr_on = CLK_1HZ;
            ST_RUN:  w_pwr_on = BMC_READY | CLK_2HZ;
            default: w_pwr_on = 1'b0;
        endcase
        if (w_in_lamp) begin
            w_pwr_on   = 1'b1;
            w_fault_on = 1'b1;
            w_id_on    = 1'b1;
        end
    end

    // Registered active-low pin drives
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_led_pwr_n   <= 1'b1;
            r_led_fault_n <= 1'b1;
            r_led_id_n    <= 1'b1;
        end else begin
            r_led_pwr_n   <= ~w_pwr_on;
            r_led_fault_n <= ~w_fault_on;
            r_led_id_n    <= ~w_id_on;
        end
    end

    assign LED_PWR_N     = r_led_pwr_n;
    assign LED_FAULT_N   = r_led_fault_n;
    assign LED_ID_N      = r_led_id_n;
    assign FAULT_LATCHED = r_fault;
    assign ID_ACTIVE     = r_id_active;
    assign STATE         = r_state;

endmodule
